// File: rtl/subservient_dbg_pkg.sv
// Shared definitions for the serial debug-to-Wishbone bridge: state encoding,
// frame field widths/offsets and the frame-length helper.
package subservient_dbg_pkg;

    typedef enum logic {
        ST_SHIFT = 1'b0,
        ST_REQ   = 1'b1
    } dbg_state_e;

    localparam int SEL_W = 4;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;

    // Field offsets inside a completed frame (LSB = last bit received).
    localparam int DAT_LSB = 0;
    localparam int ADR_LSB = DAT_LSB + DAT_W;
    localparam int SEL_LSB = ADR_LSB + ADR_W;
    localparam int WE_BIT  = SEL_LSB + SEL_W;
    localparam int ID_LSB  = WE_BIT + 1;

    function automatic int frame_len(input int aw);
        return aw + 1 + SEL_W + ADR_W + DAT_W;
    endfunction

endpackage

// File: rtl/subservient_dbg_shreg.sv
// Serial frame shift register with bit counter. The frame output already
// includes the bit being accepted so the final bit can be decoded at once.
module subservient_dbg_shreg #(
    parameter int len = 71
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    input  logic           i_bit,
    output logic [len-1:0] o_frame,
    output logic           o_first,
    output logic           o_done
);

    localparam int CNT_W = $clog2(len);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(len - 1);

    // Only len-1 bits are stored; the newest bit arrives on i_bit.
    logic [len-2:0]   frame_q, frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        frame_d = frame_q;
        cnt_d   = cnt_q;
        if (i_en) begin
            frame_d = {frame_q[len-3:0], i_bit};
            cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign o_frame = {frame_q, i_bit};
    assign o_first = i_en && (cnt_q == '0);
    assign o_done  = i_en && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_q <= '0;
            cnt_q   <= '0;
        end else begin
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/subservient_dbg_bridge.sv
// Serial debug bridge: shifts in addressed frames, issues one Wishbone access
// per matching frame and shifts the read data back out on the following frame.
module subservient_dbg_bridge
    import subservient_dbg_pkg::*;
#(
    parameter int          dbg_aw   = 2,
    parameter int          core_id  = 0,
    parameter int          timeout  = 255,
    parameter logic [31:0] err_word = 32'hDEADBEEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_dbg_data,
    input  logic        i_dbg_valid,
    output logic        o_dbg_data,
    output logic        o_dbg_busy,
    output logic        o_dbg_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    localparam int                FRAME_L  = frame_len(dbg_aw);
    localparam logic [31:0]       TMO_LAST = 32'(timeout - 1);
    localparam logic [dbg_aw-1:0] MY_ID    = dbg_aw'(core_id);

    dbg_state_e         state_q, state_d;
    logic [31:0]        rbk_q, rbk_d;
    logic [31:0]        wait_q, wait_d;
    logic               err_q, err_d;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;

    logic               shift_en;
    logic               frame_first;
    logic               frame_done;
    logic [FRAME_L-1:0] frame;

    // Bits arriving during a bus access never reach the shift register.
    assign shift_en = i_dbg_valid && (state_q == ST_SHIFT);

    subservient_dbg_shreg #(
        .len (FRAME_L)
    ) u_shreg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (shift_en),
        .i_bit   (i_dbg_data),
        .o_frame (frame),
        .o_first (frame_first),
        .o_done  (frame_done)
    );

    always_comb begin
        state_d = state_q;
        rbk_d   = rbk_q;
        wait_d  = wait_q;
        err_d   = err_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        case (state_q)
            ST_SHIFT: begin
                if (shift_en) begin
                    rbk_d = {rbk_q[30:0], 1'b0};
                end
                if (frame_first) begin
                    err_d = 1'b0;
                end
                if (frame_done && (frame[ID_LSB +: dbg_aw] == MY_ID)) begin
                    state_d = ST_REQ;
                    wait_d  = '0;
                    we_d    = frame[WE_BIT];
                    sel_d   = frame[SEL_LSB +: SEL_W];
                    adr_d   = frame[ADR_LSB +: ADR_W];
                    dat_d   = frame[DAT_LSB +: DAT_W];
                end
            end
            ST_REQ: begin
                if (i_dbg_valid) begin
                    err_d = 1'b1;
                end
                // Ack takes priority over a timeout expiring in the same cycle.
                if (i_wb_ack) begin
                    state_d = ST_SHIFT;
                    if (!we_q) begin
                        rbk_d = i_wb_rdt;
                    end
                end else if ((timeout != 0) && (wait_q == TMO_LAST)) begin
                    state_d = ST_SHIFT;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rbk_d = err_word;
                    end
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            default: state_d = ST_SHIFT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_SHIFT;
            rbk_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rbk_q   <= rbk_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    // Address, data and select only matter while stb is high.
    always_ff @(posedge i_clk) begin
        sel_q <= sel_d;
        adr_q <= adr_d;
        dat_q <= dat_d;
    end

    assign o_wb_stb   = (state_q == ST_REQ);
    assign o_dbg_busy = (state_q == ST_REQ);
    assign o_wb_we    = we_q;
    assign o_wb_sel   = sel_q;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_dbg_data = rbk_q[31];
    assign o_dbg_err  = err_q;

endmodule

// File: tb/tb_subservient_dbg_bridge.sv
// Scoreboard bench for the debug bridge: stimulus queues expected bus accesses
// and readback bits, a monitor compares them as the bridge presents them.
module tb_subservient_dbg_bridge;

    localparam int          AW    = 2;
    localparam int          MY_ID = 1;
    localparam int          TMO   = 16;
    localparam int          L     = AW + 1 + 4 + 32 + 32;
    localparam logic [31:0] ERR_W = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_data, dbg_valid;
    logic        dout, busy, err;
    logic [31:0] wb_adr, wb_dat, wb_rdt;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb, wb_ack;

    subservient_dbg_bridge #(
        .dbg_aw   (AW),
        .core_id  (MY_ID),
        .timeout  (TMO),
        .err_word (ERR_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_dbg_data  (dbg_data),
        .i_dbg_valid (dbg_valid),
        .o_dbg_data  (dout),
        .o_dbg_busy  (busy),
        .o_dbg_err   (err),
        .o_wb_adr    (wb_adr),
        .o_wb_dat    (wb_dat),
        .o_wb_sel    (wb_sel),
        .o_wb_we     (wb_we),
        .o_wb_stb    (wb_stb),
        .i_wb_rdt    (wb_rdt),
        .i_wb_ack    (wb_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          rise;
        int          len;
    } bus_t;
    typedef struct {
        int          ack_at;
        logic [31:0] rdt;
    } plan_t;
    typedef struct {
        logic dout;
        logic err;
    } bit_t;

    bus_t  exp_bus_q[$];
    plan_t plan_q[$];
    bit_t  exp_bit_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: readback word and sticky error as seen by the host.
    logic [31:0] rbk_m = '0;
    logic        err_m = 1'b0;
    int          rise_cnt = 0;
    int          exp_rise_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input bit first);
        bit_t e;
        tick();
        dbg_valid = 1'b1;
        dbg_data  = b;
        e.dout = rbk_m[31];
        e.err  = err_m;
        exp_bit_q.push_back(e);
        if (first) err_m = 1'b0;
        rbk_m = {rbk_m[30:0], 1'b0};
    endtask

    task automatic send_frame(input logic [AW-1:0] id, input logic we, input logic [3:0] sel,
                              input logic [31:0] adr, input logic [31:0] dat, output int last_cyc);
        logic [L-1:0] f;
        f = {id, we, sel, adr, dat};
        for (int i = L - 1; i >= 0; i--) begin
            if ($urandom_range(0, 7) == 0) begin
                tick();
                dbg_valid = 1'b0;
                dbg_data  = 1'($urandom);
            end
            drive_bit(f[i], i == L - 1);
        end
        last_cyc = cyc;
    endtask

    task automatic do_txn(input logic [AW-1:0] id, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat,
                          input int ack_at, input logic [31:0] rdt, input int drops);
        int    last;
        int    len;
        bit    acked;
        bus_t  b;
        plan_t p;
        send_frame(id, we, sel, adr, dat, last);
        if (id != AW'(MY_ID)) begin
            tick();
            dbg_valid = 1'b0;
            $display("txn id=%0d ignored (not addressed)", id);
            return;
        end
        acked = (ack_at >= 1) && (ack_at <= TMO);
        len   = acked ? ack_at : TMO;
        b.we = we; b.sel = sel; b.adr = adr; b.dat = dat; b.rise = last + 1; b.len = len;
        exp_bus_q.push_back(b);
        p.ack_at = ack_at; p.rdt = rdt;
        plan_q.push_back(p);
        exp_rise_cnt++;
        if (drops > len - 1) drops = len - 1;
        for (int i = 0; i < drops; i++) begin
            tick();
            dbg_valid = 1'b1;
            dbg_data  = 1'($urandom);
        end
        tick();
        dbg_valid = 1'b0;
        if (!we) rbk_m = acked ? rdt : ERR_W;
        if (!acked || drops > 0) err_m = 1'b1;
        while (cyc < last + len + 2) tick();
    endtask

    // Wishbone responder: acks on the planned stb cycle, sprinkles stray acks when idle.
    int    resp_n = 0;
    plan_t resp_p;
    initial begin
        wb_ack = 1'b0;
        wb_rdt = '0;
        resp_p.ack_at = 0;
        resp_p.rdt    = '0;
        forever begin
            @(negedge clk);
            if (wb_stb === 1'b1) begin
                if (resp_n == 0) begin
                    if (plan_q.size() > 0) begin
                        resp_p = plan_q.pop_front();
                    end else begin
                        resp_p.ack_at = 0;
                        resp_p.rdt    = '0;
                    end
                end
                resp_n++;
                wb_ack = (resp_n == resp_p.ack_at);
                wb_rdt = (resp_n == resp_p.ack_at) ? resp_p.rdt : $urandom;
            end else begin
                resp_n = 0;
                wb_ack = ($urandom_range(0, 9) == 0);
                wb_rdt = $urandom;
            end
        end
    end

    // Monitor: pops expectations whenever the bridge starts/ends an access or takes a bit.
    logic stb_prev = 1'b0;
    bit   in_txn   = 0;
    bit   unstable = 0;
    int   stb_len  = 0;
    bus_t cur;
    bit_t eb;
    initial begin
        forever begin
            @(negedge clk);
            if (wb_stb === 1'b1 && stb_prev !== 1'b1) begin
                rise_cnt++;
                checks++;
                if (exp_bus_q.size() == 0) begin
                    errors++;
                    in_txn = 0;
                    $display("FAIL spurious_stb: got stb=1 with adr %h required stb=0 (cycle %0d)", wb_adr, cyc);
                end else begin
                    cur = exp_bus_q.pop_front();
                    in_txn   = 1;
                    unstable = 0;
                    stb_len  = 1;
                    chk("stb_latency", 32'(cyc), 32'(cur.rise));
                    chk("wb_we", wb_we, cur.we);
                    chk("wb_sel", wb_sel, cur.sel);
                    chk("wb_adr", wb_adr, cur.adr);
                    chk("wb_dat", wb_dat, cur.dat);
                    chk("busy_in_req", busy, 1);
                end
            end else if (wb_stb === 1'b1) begin
                stb_len++;
                if (in_txn && (wb_we !== cur.we || wb_sel !== cur.sel ||
                               wb_adr !== cur.adr || wb_dat !== cur.dat)) unstable = 1;
            end else if (stb_prev === 1'b1 && in_txn) begin
                chk("stb_len", 32'(stb_len), 32'(cur.len));
                chk("req_stable", 32'(unstable), 0);
                $display("txn we=%0d sel=%h adr=%h dat=%h stb_cycles=%0d", cur.we, cur.sel,
                         cur.adr, cur.dat, stb_len);
                in_txn = 0;
            end
            if (dbg_valid === 1'b1 && busy === 1'b0) begin
                if (exp_bit_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_bit: bridge accepted a bit with none outstanding (cycle %0d)", cyc);
                end else begin
                    eb = exp_bit_q.pop_front();
                    chk("dbg_data", dout, eb.dout);
                    chk("dbg_err", err, eb.err);
                end
            end
            stb_prev = wb_stb;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] r_id;
    logic          r_we;
    logic [3:0]    r_sel;
    logic [31:0]   r_adr, r_dat, r_rdt;
    int            r_ack, r_drops, last_c;

    initial begin
        rst       = 1'b1;
        dbg_valid = 1'b0;
        dbg_data  = 1'b0;
        tick();
        tick();
        chk("rst_stb", wb_stb, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_dout", dout, 0);
        rst = 1'b0;
        tick();

        // Directed write, read CAFEF00D, unaddressed frame carries readback.
        do_txn(2'd1, 1'b1, 4'hF, 32'h100, 32'h12345678, 3, 32'h0, 0);
        do_txn(2'd1, 1'b0, 4'hF, 32'h200, 32'h0, 2, 32'hCAFEF00D, 0);
        do_txn(2'd2, 1'b1, 4'h3, 32'h300, 32'h55AA55AA, 1, 32'h0, 0);
        repeat (10) tick();
        chk("id2_no_stb", 32'(rise_cnt), 32'(exp_rise_cnt));
        chk("id2_stb_low", wb_stb, 0);

        // Timeout with no ack, then ack on the timeout cycle itself.
        do_txn(2'd1, 1'b0, 4'h1, 32'h400, 32'h0, 0, 32'h0, 0);
        do_txn(2'd1, 1'b0, 4'h2, 32'h404, 32'h0, TMO, 32'h0BADF00D, 0);
        do_txn(2'd1, 1'b1, 4'hC, 32'h408, 32'hA5A5A5A5, 5, 32'h0, 2);
        do_txn(2'd1, 1'b0, 4'hF, 32'h40C, 32'h0, 1, 32'h13579BDF, 0);

        // Reset while an access is outstanding.
        send_frame(2'd1, 1'b0, 4'hF, 32'h500, 32'h0, last_c);
        cur.we = 1'b0;
        begin
            bus_t  b;
            plan_t p;
            b.we = 1'b0; b.sel = 4'hF; b.adr = 32'h500; b.dat = 32'h0; b.rise = last_c + 1; b.len = 3;
            exp_bus_q.push_back(b);
            p.ack_at = 0; p.rdt = '0;
            plan_q.push_back(p);
            exp_rise_cnt++;
        end
        tick();
        dbg_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rbk_m = '0;
        err_m = 1'b0;
        chk("rst_req_stb", wb_stb, 0);
        chk("rst_req_busy", busy, 0);
        chk("rst_req_err", err, 0);

        // Partial frame abandoned by reset; the next full frame must align.
        for (int i = 0; i < 20; i++) drive_bit(1'($urandom), i == 0);
        tick();
        dbg_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rbk_m = '0;
        err_m = 1'b0;
        do_txn(2'd1, 1'b1, 4'h6, 32'h600, 32'hFEEDFACE, 4, 32'h0, 0);

        for (int t = 0; t < 25; t++) begin
            r_id    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'(MY_ID);
            r_we    = 1'($urandom);
            r_sel   = 4'($urandom);
            r_adr   = $urandom;
            r_dat   = $urandom;
            r_rdt   = $urandom;
            r_ack   = $urandom_range(0, 20);
            r_drops = $urandom_range(0, 2);
            do_txn(r_id, r_we, r_sel, r_adr, r_dat, r_ack, r_rdt, r_drops);
        end
        // Final unaddressed frame shifts out the last readback word.
        do_txn(2'd0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0);
        repeat (5) tick();

        chk("bus_q_drained", 32'(exp_bus_q.size()), 0);
        chk("bit_q_drained", 32'(exp_bit_q.size()), 0);
        chk("no_open_txn", 32'(in_txn), 0);
        chk("stb_count", 32'(rise_cnt), 32'(exp_rise_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
